// File: rtl/systolic_result_drain.sv
// Buffers up to DEPTH N-lane accumulator vectors and drains the head one saturated lane per cycle.
// Latency: element 0 is visible the cycle after the push; vec_ready is registered state only; outputs hold while out_ready is low.
module systolic_result_drain #(
   parameter int DIN_WIDTH = 8,
   parameter int N         = 4,
   parameter int ACC_WIDTH = 2*DIN_WIDTH,
   parameter int OUT_WIDTH = 2*DIN_WIDTH,
   parameter int DEPTH     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         vec_valid,
   output logic                         vec_ready,
   input  logic [N*ACC_WIDTH-1:0]       vec_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH-1:0]         c_dout,
   output logic [$clog2(N)-1:0]         c_dout_idx,
   output logic                         c_last,
   output logic                         sat_flag,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int IW = $clog2(N);
   localparam int LW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [N*ACC_WIDTH-1:0]        mem [DEPTH];
   logic [PW-1:0]                 wr_ptr;
   logic [PW-1:0]                 rd_ptr;
   logic [LW-1:0]                 cnt;
   logic [IW-1:0]                 idx;
   logic                          push;
   logic                          xfer;
   logic                          pop;
   logic                          idx_last;
   logic signed [ACC_WIDTH-1:0]   head_elem;
   logic [OUT_WIDTH-1:0]          sat_val;
   logic                          sat_hit;

   // Pointers wrap at DEPTH explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign vec_ready = !rst && (cnt < LW'(DEPTH));
   assign out_valid = !rst && (cnt != '0);
   assign push      = vec_valid && vec_ready;
   assign xfer      = out_valid && out_ready;
   assign idx_last  = (idx == IW'(N-1));
   assign pop       = xfer && idx_last;
   assign head_elem = mem[rd_ptr][idx*ACC_WIDTH +: ACC_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         idx    <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_next(wr_ptr);
         if (pop)
            rd_ptr <= ptr_next(rd_ptr);
         if (xfer)
            idx <= idx_last ? '0 : idx + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (pop && !push)
            cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= vec_data;
   end

   generate
      if (OUT_WIDTH < ACC_WIDTH) begin : g_sat
         // In range exactly when all bits from the output sign bit upward agree.
         logic [ACC_WIDTH-OUT_WIDTH:0] upper;
         assign upper = head_elem[ACC_WIDTH-1:OUT_WIDTH-1];
         always_comb begin
            sat_hit = !((&upper) || !(|upper));
            if (!sat_hit)
               sat_val = head_elem[OUT_WIDTH-1:0];
            else if (head_elem[ACC_WIDTH-1])
               sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            else
               sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
         end
      end else begin : g_pass
         assign sat_val = head_elem[OUT_WIDTH-1:0];
         assign sat_hit = 1'b0;
      end
   endgenerate

   assign c_dout     = out_valid ? sat_val : '0;
   assign c_dout_idx = out_valid ? idx : '0;
   assign c_last     = out_valid && idx_last;
   assign sat_flag   = out_valid && sat_hit;
   assign level      = cnt;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain (N=4, ACC_WIDTH=16, OUT_WIDTH=8, DEPTH=2).
module tb_systolic_result_drain;
   localparam int N = 4;
   localparam int ACC_WIDTH = 16;
   localparam int OUT_WIDTH = 8;
   localparam int DEPTH = 2;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    vec_valid = 1'b0;
   logic                    vec_ready;
   logic [N*ACC_WIDTH-1:0]  vec_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [OUT_WIDTH-1:0]    c_dout;
   logic [1:0]              c_dout_idx;
   logic                    c_last;
   logic                    sat_flag;
   logic [1:0]              level;

   typedef struct {
      logic [7:0] dout;
      int         idx;
      bit         last;
      bit         sat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rdy_mode = 3;   // 0: always ready, 1: random, 2: held low, 3: driven by the test

   systolic_result_drain #(
      .DIN_WIDTH(8), .N(N), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
      .out_valid(out_valid), .out_ready(out_ready), .c_dout(c_dout), .c_dout_idx(c_dout_idx),
      .c_last(c_last), .sat_flag(sat_flag), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk_exp(input int x, input int j);
      exp_t e;
      int   d;
      e.idx  = j;
      e.last = (j == N-1);
      if (x > 127) begin
         d = 127; e.sat = 1'b1;
      end else if (x < -128) begin
         d = -128; e.sat = 1'b1;
      end else begin
         d = x; e.sat = 1'b0;
      end
      e.dout = d[7:0];
      return e;
   endfunction

   // Ready driver
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(0, 3) != 0);
         2: out_ready = 1'b0;
         default: ;
      endcase
   end

   // Monitor: compares against the model state reflecting all edges so far
   int mon_lv;
   always @(negedge clk) begin
      if (rst) begin
         check("rst_vec_ready", {31'd0, vec_ready}, 32'd0);
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
         mon_lv = (sb.size() + N - 1) / N;
         check("level", {30'd0, level}, mon_lv);
         check("vec_ready", {31'd0, vec_ready}, {31'd0, mon_lv < DEPTH});
         check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
         if (out_valid && sb.size() != 0) begin
            check("c_dout", {24'd0, c_dout}, {24'd0, sb[0].dout});
            check("c_dout_idx", {30'd0, c_dout_idx}, sb[0].idx);
            check("c_last", {31'd0, c_last}, {31'd0, sb[0].last});
            check("sat_flag", {31'd0, sat_flag}, {31'd0, sb[0].sat});
            if (out_ready)
               void'(sb.pop_front());
         end else if (!out_valid) begin
            check("idle_zero", {20'd0, c_dout, c_dout_idx, c_last, sat_flag}, 32'd0);
         end
      end
   end

   task automatic send_vec(input int l0, input int l1, input int l2, input int l3);
      int  lanes[4];
      bit  done;
      lanes = '{l0, l1, l2, l3};
      done = 1'b0;
      for (int i = 0; i < N; i++)
         vec_data[i*ACC_WIDTH +: ACC_WIDTH] = 16'(lanes[i]);
      vec_valid = 1'b1;
      for (int t = 0; t < 500 && !done; t++) begin
         @(negedge clk);
         if (vec_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      vec_valid = 1'b0;
      if (!done)
         check("push_timeout", 32'd0, 32'd1);
      else
         for (int j = 0; j < N; j++)
            sb.push_back(mk_exp(lanes[j], j));
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) sb.delete();
         if (c < cycles - 1) begin
            @(negedge clk);
            check("rst_level", {30'd0, level}, 32'd0);
            @(posedge clk);
            #1;
            c++;
         end
      end
      rst = 1'b0;
      vec_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
   endtask

   function automatic int rnd_lane();
      shortint s;
      if ($urandom_range(0, 2) == 0) s = shortint'($urandom);
      else s = shortint'(int'($urandom_range(0, 300)) - 150);
      return int'(s);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with vec_valid held high: nothing may be stored
      vec_valid = 1'b1;
      vec_data  = 64'h1234_5678_9abc_def0;
      do_reset(2);
      @(negedge clk);
      check("post_rst_vec_ready", {31'd0, vec_ready}, 32'd1);
      @(posedge clk); #1;

      // Single vector, free-running consumer
      rdy_mode = 0;
      send_vec(5, -3, 100, 300);
      wait_drain();
      repeat (2) @(posedge clk);
      #1;

      // Backpressure while idx=1
      rdy_mode = 3;
      out_ready = 1'b1;
      send_vec(-200, 7, 8, 9);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_hold_dout", {24'd0, c_dout}, 32'h07);
         check("bp_hold_idx", {30'd0, c_dout_idx}, 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_drain();

      // Full: three offered with consumer stalled, release later
      rdy_mode = 2;
      @(posedge clk); #1;
      fork
         begin
            send_vec(1, 2, 3, 4);
            send_vec(-1000, 1000, -128, 127);
            send_vec(10, 20, 30, 40);
         end
         begin
            repeat (6) @(posedge clk);
            @(negedge clk);
            check("full_level", {30'd0, level}, 32'd2);
            check("full_vec_ready", {31'd0, vec_ready}, 32'd0);
            rdy_mode = 0;
         end
      join
      wait_drain();

      // Streaming: push lands on the pop edge with level=1
      rdy_mode = 0;
      @(posedge clk); #1;
      send_vec(11, 12, 13, 14);
      repeat (3) @(posedge clk);
      #1;
      send_vec(-21, 22, -23, 24);
      @(negedge clk);
      check("stream_level", {30'd0, level}, 32'd1);
      check("stream_idx", {30'd0, c_dout_idx}, 32'd0);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      wait_drain();

      // Reset mid-operation at level=2, idx=2
      rdy_mode = 3;
      out_ready = 1'b0;
      @(posedge clk); #1;
      send_vec(50, 60, 70, 80);
      send_vec(90, 91, 92, 93);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_idx", {30'd0, c_dout_idx}, 32'd2);
      @(posedge clk); #1;
      do_reset(1);
      @(negedge clk);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_level", {30'd0, level}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_vec(-300, 127, -129, 128);
      wait_drain();

      // Randomised traffic with random consumer stalls
      rdy_mode = 1;
      for (int v = 0; v < 60; v++) begin
         send_vec(rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
         if ($urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 6)) @(posedge clk);
         #1;
      end
      rdy_mode = 0;
      wait_drain();
      repeat (3) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Parametrised output stage for the systolic array. Accepts one full vector of N accumulator results per handshake and buffers up to DEPTH vectors. Serialises the head vector onto a single c_dout lane with element index, last flag, optional signed saturation, and ready/valid backpressure. Replaces the fixed-width, no-backpressure c_dout/c_dout_idx path with a width-, depth- and lane-generic drain.

Parameters:
DIN_WIDTH, 8, operand width of the array (informational; sets the ACC_WIDTH default)
N, 4, lanes per result vector; N >= 2
ACC_WIDTH, 2*DIN_WIDTH, width of each signed accumulator result
OUT_WIDTH, 2*DIN_WIDTH, width of c_dout; 2 <= OUT_WIDTH <= ACC_WIDTH
DEPTH, 2, vectors buffered; DEPTH >= 1

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
vec_valid  in  1  vec_data valid
vec_ready  out  1  drain can accept a vector
vec_data  in  N*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH], signed
out_valid  out  1  c_dout valid
out_ready  in  1  consumer accepts c_dout
c_dout  out  OUT_WIDTH  current element, signed, saturated
c_dout_idx  out  $clog2(N)  lane index of c_dout
c_last  out  1  c_dout_idx == N-1
sat_flag  out  1  current element was clipped
level  out  $clog2(DEPTH+1)  vectors stored, including the partially drained head

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, index counter = 0, level = 0. While rst is high: vec_ready=0 and out_valid=0. c_dout, c_dout_idx, c_last and sat_flag read 0 whenever out_valid=0.
- Reset mid-operation discards all stored and partially drained vectors. There is no residual output after rst drops.
- vec_ready = !rst && (level < DEPTH). It is registered-state only, with no combinational path from out_ready. When full, vec_ready=0 even if a pop occurs in the same cycle.
- Push: on an edge where vec_valid && vec_ready, vec_data is written to the tail.
- out_valid = (level != 0).
- c_dout is the saturated value of head[c_dout_idx].
- Latency: a vector pushed at edge k into an empty FIFO gives out_valid=1 in the cycle following edge k, with idx 0. Element j of that vector appears at the earliest in the cycle following edge k+j.
- Transfer: on an edge where out_valid && out_ready:
  - If idx < N-1: idx increments.
  - If idx == N-1: the head is popped and idx returns to 0.
- While out_valid && !out_ready: c_dout, c_dout_idx, c_last and sat_flag hold stable.
- Simultaneous push and pop at the same edge: level is unchanged, and the next vector's element 0 follows the previous element N-1 with no bubble.
- level changes as follows:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- FIFO pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Saturation when OUT_WIDTH < ACC_WIDTH:
  - Let x = head[idx].
  - If x > 2^(OUT_WIDTH-1)-1: c_dout = 2^(OUT_WIDTH-1)-1 and sat_flag = 1.
  - If x < -2^(OUT_WIDTH-1): c_dout = -2^(OUT_WIDTH-1) and sat_flag = 1.
  - Otherwise: c_dout = x[OUT_WIDTH-1:0] and sat_flag = 0.
- When OUT_WIDTH == ACC_WIDTH: pass-through, sat_flag is always 0.
- Incoming vectors are not modified. Saturation applies at the output only.

Test Plan:
(all cases N=4, ACC_WIDTH=16, OUT_WIDTH=8, DEPTH=2)
1. Reset: hold rst=1 for 2 cycles with vec_valid=1 -> vec_ready=0, out_valid=0, level=0, nothing stored. First cycle after release: vec_ready=1.
2. Single vector, lanes {5, -3, 100, 300}, out_ready=1 -> over 4 consecutive cycles:
   - c_dout = 0x05, 0xFD, 0x64, 0x7F.
   - idx = 0, 1, 2, 3.
   - sat_flag = 0, 0, 0, 1.
   - c_last only at idx 3.
   - Then out_valid=0 and level=0.
3. Backpressure: during vector {-200, 7, 8, 9}, drop out_ready for 3 cycles while idx=1 -> c_dout=0x07 and idx=1 held stable. On resume: 0x08, then 0x09. First element reads 0x80 with sat_flag=1.
4. Full: out_ready=0, offer 3 vectors back-to-back -> 2 accepted, level=2, vec_ready=0, third held at the input. Raise out_ready -> third accepted only in the cycle after the first pop, i.e. not in the pop cycle itself.
5. Streaming: push a new vector at the same edge as the pop of idx 3 with level=1 -> level stays 1, and the next element 0 is presented in the very next cycle.
6. Reset mid-operation: assert rst while level=2 and idx=2 -> the following cycle has out_valid=0 and level=0. A subsequent vector drains from idx 0.
